// File: rtl/mult_div_unit.sv
// -----------------------------------------------------------------------------
// mult_div_unit
//
// Iterative multiply/divide unit for the EX stage of a five-stage MIPS
// pipeline. It implements mult, multu, div and divu into the architectural
// HI/LO registers and performs one shift-add (multiply) or one restoring
// shift-subtract (divide) step per clock.
//
// Configuration macro:
//   MULT_DIV_DIVIDE_EN  defined   -> divider datapath present.
//                       undefined -> divider removed; div/divu are accepted,
//                                    end one cycle later with Done and leave
//                                    HI/LO unchanged (DivByZero stays 0).
//
// Ports:
//   clock      in   1  system clock, rising edge active
//   reset      in   1  asynchronous, active-high reset
//   Start      in   1  operation request, sampled only while Busy=0
//   Op         in   2  00 mult, 01 multu, 10 div, 11 divu
//   inA        in   N  multiplicand / dividend
//   inB        in   N  multiplier / divisor
//   Flush      in   1  abort the operation in flight
//   Busy       out  1  operation in progress
//   Done       out  1  one-cycle pulse when an operation completes
//   DivByZero  out  1  one-cycle pulse with Done for a divide by zero
//   HI         out  N  high product word / remainder
//   LO         out  N  low product word / quotient
// -----------------------------------------------------------------------------
module mult_div_unit #(
    parameter int N = 32
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         Start,
    input  logic [1:0]   Op,
    input  logic [N-1:0] inA,
    input  logic [N-1:0] inB,
    input  logic         Flush,
    output logic         Busy,
    output logic         Done,
    output logic         DivByZero,
    output logic [N-1:0] HI,
    output logic [N-1:0] LO
);

    localparam int            CW        = 6;
    localparam logic [CW-1:0] LAST_ITER = CW'(N - 1);
    localparam logic [CW-1:0] CNT_ONE   = {{(CW-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        CALC = 2'b01,
        FIX  = 2'b10
    } state_t;

    state_t         state_r;
    state_t         state_s;

    logic [CW-1:0]  cnt_r;
    // Multiply: {partial product, remaining multiplier bits}.
    // Divide:   {partial remainder, dividend bits becoming quotient bits}.
    logic [2*N-1:0] acc_r;
    // Multiplicand magnitude for multiply, divisor magnitude for divide.
    logic [N-1:0]   opnd_r;
    logic           neg_lo_r;      // product or quotient must be negated
    logic           nowrite_r;     // finish without touching HI/LO
    logic           busy_r;
    logic           done_r;
    logic           dbz_out_r;
    logic [N-1:0]   hi_r;
    logic [N-1:0]   lo_r;

    logic           signed_s;
    logic           a_neg_s;
    logic           b_neg_s;
    logic [N-1:0]   a_mag_s;
    logic [N-1:0]   b_mag_s;
    logic           accept_s;
    logic           skip_s;

    logic [N:0]     mul_add_s;
    logic [N:0]     mul_sum_s;
    logic [2*N-1:0] mul_next_s;
    logic [2*N-1:0] iter_next_s;
    logic [2*N-1:0] prod_fix_s;
    logic [N-1:0]   fix_hi_s;
    logic [N-1:0]   fix_lo_s;

`ifdef MULT_DIV_DIVIDE_EN
    logic           is_div_r;
    logic           neg_hi_r;      // remainder takes the dividend's sign
    logic           dbz_r;
    logic [N:0]     div_diff_s;
    logic [2*N-1:0] div_next_s;
`endif

    // Operand decode: magnitudes and signs for the signed variants
    always_comb begin
        signed_s = ~Op[0];
        a_neg_s  = signed_s & inA[N-1];
        b_neg_s  = signed_s & inB[N-1];
        if (a_neg_s) begin
            a_mag_s = {N{1'b0}} - inA;
        end else begin
            a_mag_s = inA;
        end
        if (b_neg_s) begin
            b_mag_s = {N{1'b0}} - inB;
        end else begin
            b_mag_s = inB;
        end
        accept_s = (state_r == IDLE) & Start & ~Flush;
`ifdef MULT_DIV_DIVIDE_EN
        skip_s   = Op[1] & (inB == {N{1'b0}});
`else
        skip_s   = Op[1];
`endif
    end

    // Radix-2 shift-add multiply step: add multiplicand if the current
    // multiplier bit is set, then shift the whole accumulator right
    always_comb begin
        if (acc_r[0]) begin
            mul_add_s = {1'b0, opnd_r};
        end else begin
            mul_add_s = {(N+1){1'b0}};
        end
        mul_sum_s  = {1'b0, acc_r[2*N-1:N]} + mul_add_s;
        mul_next_s = {mul_sum_s, acc_r[N-1:1]};
    end

`ifdef MULT_DIV_DIVIDE_EN
    // Restoring divide step: trial-subtract the divisor from the shifted
    // remainder; keep the difference and shift in a 1 only if it did not borrow
    always_comb begin
        div_diff_s = acc_r[2*N-1:N-1] - {1'b0, opnd_r};
        if (div_diff_s[N]) begin
            div_next_s = {acc_r[2*N-2:0], 1'b0};
        end else begin
            div_next_s = {div_diff_s[N-1:0], acc_r[N-2:0], 1'b1};
        end
    end
`endif

    // Select the iteration result and compute the sign-fixed HI/LO values
    always_comb begin
`ifdef MULT_DIV_DIVIDE_EN
        if (is_div_r) begin
            iter_next_s = div_next_s;
        end else begin
            iter_next_s = mul_next_s;
        end
`else
        iter_next_s = mul_next_s;
`endif
        if (neg_lo_r) begin
            prod_fix_s = {(2*N){1'b0}} - acc_r;
        end else begin
            prod_fix_s = acc_r;
        end
        fix_hi_s = prod_fix_s[2*N-1:N];
        fix_lo_s = prod_fix_s[N-1:0];
`ifdef MULT_DIV_DIVIDE_EN
        if (is_div_r) begin
            if (neg_lo_r) begin
                fix_lo_s = {N{1'b0}} - acc_r[N-1:0];
            end else begin
                fix_lo_s = acc_r[N-1:0];
            end
            if (neg_hi_r) begin
                fix_hi_s = {N{1'b0}} - acc_r[2*N-1:N];
            end else begin
                fix_hi_s = acc_r[2*N-1:N];
            end
        end else begin
            fix_hi_s = prod_fix_s[2*N-1:N];
            fix_lo_s = prod_fix_s[N-1:0];
        end
`endif
    end

    // FSM next-state logic
    always_comb begin
        state_s = state_r;
        case (state_r)
            IDLE: begin
                if (accept_s) begin
                    if (skip_s) begin
                        state_s = FIX;
                    end else begin
                        state_s = CALC;
                    end
                end else begin
                    state_s = IDLE;
                end
            end
            CALC: begin
                if (Flush) begin
                    state_s = IDLE;
                end else if (cnt_r == LAST_ITER) begin
                    state_s = FIX;
                end else begin
                    state_s = CALC;
                end
            end
            FIX: begin
                state_s = IDLE;
            end
            default: begin
                state_s = IDLE;
            end
        endcase
    end

    // FSM state register
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Operand capture, per-cycle iteration and the HI/LO write in FIX
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            cnt_r     <= {CW{1'b0}};
            acc_r     <= {(2*N){1'b0}};
            opnd_r    <= {N{1'b0}};
            neg_lo_r  <= 1'b0;
            nowrite_r <= 1'b0;
            hi_r      <= {N{1'b0}};
            lo_r      <= {N{1'b0}};
`ifdef MULT_DIV_DIVIDE_EN
            is_div_r  <= 1'b0;
            neg_hi_r  <= 1'b0;
            dbz_r     <= 1'b0;
`endif
        end else begin
            case (state_r)
                IDLE: begin
                    if (accept_s) begin
                        opnd_r    <= Op[1] ? b_mag_s : a_mag_s;
                        acc_r     <= {{N{1'b0}}, (Op[1] ? a_mag_s : b_mag_s)};
                        neg_lo_r  <= a_neg_s ^ b_neg_s;
                        nowrite_r <= skip_s;
                        cnt_r     <= {CW{1'b0}};
`ifdef MULT_DIV_DIVIDE_EN
                        is_div_r  <= Op[1];
                        neg_hi_r  <= a_neg_s;
                        dbz_r     <= skip_s;
`endif
                    end
                end
                CALC: begin
                    if (!Flush) begin
                        acc_r <= iter_next_s;
                        cnt_r <= cnt_r + CNT_ONE;
                    end
                end
                FIX: begin
                    if (!Flush && !nowrite_r) begin
                        hi_r <= fix_hi_s;
                        lo_r <= fix_lo_s;
                    end
                end
                default: begin
                    cnt_r <= {CW{1'b0}};
                end
            endcase
        end
    end

    // Registered status outputs
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            busy_r    <= 1'b0;
            done_r    <= 1'b0;
            dbz_out_r <= 1'b0;
        end else begin
            busy_r    <= (state_s != IDLE);
            done_r    <= (state_r == FIX) && !Flush;
`ifdef MULT_DIV_DIVIDE_EN
            dbz_out_r <= (state_r == FIX) && !Flush && dbz_r;
`else
            dbz_out_r <= 1'b0;
`endif
        end
    end

    assign Busy      = busy_r;
    assign Done      = done_r;
    assign DivByZero = dbz_out_r;
    assign HI        = hi_r;
    assign LO        = lo_r;

endmodule

// File: tb/tb_mult_div_unit.sv
// -----------------------------------------------------------------------------
// tb_mult_div_unit
//
// Self-checking bench for mult_div_unit. Expected HI/LO come from 64-bit
// integer arithmetic (signed/unsigned multiply, truncating divide, remainder
// with the dividend's sign); timing expectations come from the fixed latency
// of N+1 cycles (one cycle for operations that end without a write).
// -----------------------------------------------------------------------------
module tb_mult_div_unit;

    localparam int N = 32;
`ifdef MULT_DIV_DIVIDE_EN
    localparam bit DIV_EN = 1'b1;
`else
    localparam bit DIV_EN = 1'b0;
`endif

    logic          clock;
    logic          reset;
    logic          Start;
    logic [1:0]    Op;
    logic [N-1:0]  inA;
    logic [N-1:0]  inB;
    logic          Flush;
    logic          Busy;
    logic          Done;
    logic          DivByZero;
    logic [N-1:0]  HI;
    logic [N-1:0]  LO;

    int            n_compared;
    int            n_mismatched;

    // reference model state
    logic [N-1:0]  model_hi;
    logic [N-1:0]  model_lo;
    bit            exp_nowrite;
    bit            exp_dbz;

    mult_div_unit #(.N(N)) dut (
        .clock     (clock),
        .reset     (reset),
        .Start     (Start),
        .Op        (Op),
        .inA       (inA),
        .inB       (inB),
        .Flush     (Flush),
        .Busy      (Busy),
        .Done      (Done),
        .DivByZero (DivByZero),
        .HI        (HI),
        .LO        (LO)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Reference model: architectural result of one operation
    task automatic model_op(input logic [1:0] op, input logic [N-1:0] a, input logic [N-1:0] b);
        longint          sa;
        longint          sb;
        longint          p;
        longint          q;
        longint          r;
        longint unsigned ua;
        longint unsigned ub;
        longint unsigned pu;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = {32'd0, a};
        ub = {32'd0, b};
        exp_nowrite = 1'b0;
        exp_dbz     = 1'b0;
        case (op)
            2'b00: begin
                p = sa * sb;
                model_hi = p[63:32];
                model_lo = p[31:0];
            end
            2'b01: begin
                pu = ua * ub;
                model_hi = pu[63:32];
                model_lo = pu[31:0];
            end
            default: begin
                if (!DIV_EN) begin
                    exp_nowrite = 1'b1;
                end else if (b == 32'd0) begin
                    exp_nowrite = 1'b1;
                    exp_dbz     = 1'b1;
                end else if (op == 2'b10) begin
                    q = sa / sb;
                    r = sa % sb;
                    model_lo = q[31:0];
                    model_hi = r[31:0];
                end else begin
                    pu = ua / ub;
                    model_lo = pu[31:0];
                    pu = ua % ub;
                    model_hi = pu[31:0];
                end
            end
        endcase
    endtask

    // Issue one operation and observe N+4 cycles, scrambling the operand
    // inputs while busy. Observation index k=1 is the negedge after accept.
    task automatic do_op(input logic [1:0] op, input logic [N-1:0] a, input logic [N-1:0] b,
                         output int busy_cnt, output int done_at, output int done_cnt,
                         output int dbz_at, output int dbz_cnt);
        busy_cnt = 0; done_at = 0; done_cnt = 0; dbz_at = 0; dbz_cnt = 0;
        @(negedge clock);
        Start = 1'b1; Op = op; inA = a; inB = b;
        @(negedge clock);
        Start = 1'b0;
        for (int k = 1; k <= N + 4; k++) begin
            if (k > 1) @(negedge clock);
            if (Busy) busy_cnt++;
            if (Done) begin done_cnt++; done_at = k; end
            if (DivByZero) begin dbz_cnt++; dbz_at = k; end
            inA = $urandom; inB = $urandom; Op = 2'($urandom);
        end
    endtask

    // Run one operation and check it entirely against the model
    task automatic run_checked(input string name, input logic [1:0] op,
                               input logic [N-1:0] a, input logic [N-1:0] b);
        int bc, da, dc, za, zc;
        int exp_busy, exp_done_at;
        model_op(op, a, b);
        exp_busy    = exp_nowrite ? 1 : N + 1;
        exp_done_at = exp_nowrite ? 2 : N + 2;
        do_op(op, a, b, bc, da, dc, za, zc);
        n_compared++;
        if (HI !== model_hi) begin n_mismatched++; $display("FAIL %s HI: got %h expected %h", name, HI, model_hi); end
        n_compared++;
        if (LO !== model_lo) begin n_mismatched++; $display("FAIL %s LO: got %h expected %h", name, LO, model_lo); end
        n_compared++;
        if (bc !== exp_busy) begin n_mismatched++; $display("FAIL %s busy_cycles: got %0d expected %0d", name, bc, exp_busy); end
        n_compared++;
        if (da !== exp_done_at || dc !== 1) begin
            n_mismatched++;
            $display("FAIL %s done: got at %0d x%0d expected at %0d x1", name, da, dc, exp_done_at);
        end
        n_compared++;
        if (exp_dbz ? (za !== 2 || zc !== 1) : (zc !== 0)) begin
            n_mismatched++;
            $display("FAIL %s divbyzero: got at %0d x%0d expected x%0d", name, za, zc, exp_dbz ? 1 : 0);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1; Start = 1'b0; Flush = 1'b0; Op = 2'b00; inA = '0; inB = '0;
        repeat (2) @(negedge clock);
        n_compared++;
        if ({Busy, Done, DivByZero} !== 3'b000) begin n_mismatched++; $display("FAIL reset_flags: got %b expected 000", {Busy, Done, DivByZero}); end
        n_compared++;
        if (HI !== 32'd0 || LO !== 32'd0) begin n_mismatched++; $display("FAIL reset_hilo: got %h/%h expected 0/0", HI, LO); end
        reset = 1'b0;
        model_hi = 32'd0; model_lo = 32'd0;
        @(negedge clock);
    endtask

    task automatic test_directed();
        run_checked("mult_7x-3", 2'b00, 32'd7, 32'hFFFF_FFFD);
        n_compared++;
        if (HI !== 32'hFFFF_FFFF || LO !== 32'hFFFF_FFEB) begin n_mismatched++; $display("FAIL mult_const: got %h/%h expected ffffffff/ffffffeb", HI, LO); end
        run_checked("multu_max", 2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        n_compared++;
        if (HI !== 32'hFFFF_FFFE || LO !== 32'h0000_0001) begin n_mismatched++; $display("FAIL multu_const: got %h/%h expected fffffffe/00000001", HI, LO); end
        run_checked("div_-7/2", 2'b10, 32'hFFFF_FFF9, 32'd2);
        if (DIV_EN) begin
            n_compared++;
            if (HI !== 32'hFFFF_FFFF || LO !== 32'hFFFF_FFFD) begin n_mismatched++; $display("FAIL div_trunc_const: got %h/%h expected ffffffff/fffffffd", HI, LO); end
        end
        run_checked("div_ovf", 2'b10, 32'h8000_0000, 32'hFFFF_FFFF);
        if (DIV_EN) begin
            n_compared++;
            if (HI !== 32'd0 || LO !== 32'h8000_0000) begin n_mismatched++; $display("FAIL div_ovf_const: got %h/%h expected 00000000/80000000", HI, LO); end
        end
    endtask

    task automatic test_div_by_zero();
        // 0x22 * 0x80000001 = 0x00000011_00000022
        run_checked("preload", 2'b01, 32'h0000_0022, 32'h8000_0001);
        n_compared++;
        if (HI !== 32'h11 || LO !== 32'h22) begin n_mismatched++; $display("FAIL preload_const: got %h/%h expected 11/22", HI, LO); end
        run_checked("divu_by_zero", 2'b11, 32'd100, 32'd0);
        n_compared++;
        if (HI !== 32'h11 || LO !== 32'h22) begin n_mismatched++; $display("FAIL dbz_hold: got %h/%h expected 11/22", HI, LO); end
    endtask

    task automatic test_flush();
        int done_seen;
        int busy_seen;
        @(negedge clock);
        Start = 1'b1; Op = 2'b01; inA = $urandom; inB = $urandom;
        @(negedge clock);                      // E0 has passed
        Start = 1'b0;
        repeat (9) @(negedge clock);           // next posedge is E0+10
        Flush = 1'b1;
        @(negedge clock);
        Flush = 1'b0;
        n_compared++;
        if (Busy !== 1'b0) begin n_mismatched++; $display("FAIL flush_busy: got %b expected 0", Busy); end
        done_seen = 0; busy_seen = 0;
        for (int k = 0; k < N + 4; k++) begin
            @(negedge clock);
            if (Done) done_seen++;
            if (Busy) busy_seen++;
        end
        n_compared++;
        if (done_seen !== 0 || busy_seen !== 0) begin n_mismatched++; $display("FAIL flush_quiet: got done=%0d busy=%0d expected 0/0", done_seen, busy_seen); end
        n_compared++;
        if (HI !== model_hi || LO !== model_lo) begin n_mismatched++; $display("FAIL flush_hilo: got %h/%h expected %h/%h", HI, LO, model_hi, model_lo); end
        // Flush together with Start in IDLE: nothing accepted
        Start = 1'b1; Flush = 1'b1; Op = 2'b00; inA = 32'd3; inB = 32'd5;
        @(negedge clock);
        Start = 1'b0; Flush = 1'b0;
        done_seen = 0; busy_seen = 0;
        for (int k = 0; k < 4; k++) begin
            if (Done) done_seen++;
            if (Busy) busy_seen++;
            @(negedge clock);
        end
        n_compared++;
        if (done_seen !== 0 || busy_seen !== 0 || HI !== model_hi || LO !== model_lo) begin
            n_mismatched++;
            $display("FAIL flush_start_idle: got done=%0d busy=%0d hi=%h lo=%h", done_seen, busy_seen, HI, LO);
        end
    endtask

    task automatic test_back_to_back();
        logic [N-1:0] a2, b2;
        logic [N-1:0] first_hi, first_lo;
        int           k2;
        a2 = $urandom; b2 = $urandom;
        model_op(2'b00, 32'h1234_5678, 32'hFEDC_BA98);
        first_hi = model_hi; first_lo = model_lo;
        @(negedge clock);
        Start = 1'b1; Op = 2'b00; inA = 32'h1234_5678; inB = 32'hFEDC_BA98;
        // Start stays high throughout: every request while busy is ignored
        for (int k = 1; k <= N + 1; k++) begin
            @(negedge clock);
            Op = 2'($urandom); inA = $urandom; inB = $urandom;
        end
        @(negedge clock);                      // k = N+2: completion cycle
        n_compared++;
        if (Busy !== 1'b0 || Done !== 1'b1) begin n_mismatched++; $display("FAIL b2b_done_cycle: got busy=%b done=%b expected 0/1", Busy, Done); end
        n_compared++;
        if (HI !== first_hi || LO !== first_lo) begin n_mismatched++; $display("FAIL b2b_first: got %h/%h expected %h/%h", HI, LO, first_hi, first_lo); end
        Op = 2'b01; inA = a2; inB = b2;         // accepted at the next edge
        model_op(2'b01, a2, b2);
        @(negedge clock);
        Start = 1'b0;
        n_compared++;
        if (Busy !== 1'b1) begin n_mismatched++; $display("FAIL b2b_reaccept: got busy=%b expected 1", Busy); end
        k2 = 0;
        while (!Done && k2 < N + 8) begin
            @(negedge clock);
            k2++;
        end
        n_compared++;
        if (!Done) begin n_mismatched++; $display("FAIL b2b_timeout: got no Done within %0d cycles expected Done", N + 8); end
        n_compared++;
        if (HI !== model_hi || LO !== model_lo) begin n_mismatched++; $display("FAIL b2b_second: got %h/%h expected %h/%h", HI, LO, model_hi, model_lo); end
        @(negedge clock);
    endtask

    task automatic test_async_reset();
        @(negedge clock);
        Start = 1'b1; Op = 2'b01; inA = $urandom; inB = $urandom;
        @(posedge clock);                      // E0
        #1 Start = 1'b0;
        repeat (5) @(posedge clock);           // E0+5
        #2 reset = 1'b1;
        #1;
        n_compared++;
        if ({Busy, Done, DivByZero} !== 3'b000 || HI !== 32'd0 || LO !== 32'd0) begin
            n_mismatched++;
            $display("FAIL async_reset: got busy=%b done=%b dbz=%b hi=%h lo=%h expected all 0", Busy, Done, DivByZero, HI, LO);
        end
        @(negedge clock);
        reset = 1'b0;
        model_hi = 32'd0; model_lo = 32'd0;
        @(negedge clock);
    endtask

    function automatic logic [N-1:0] pick_value();
        case ($urandom_range(0, 7))
            0:       return 32'h0000_0000;
            1:       return 32'h0000_0001;
            2:       return 32'hFFFF_FFFF;
            3:       return 32'h8000_0000;
            4:       return 32'h7FFF_FFFF;
            default: return $urandom;
        endcase
    endfunction

    task automatic test_random();
        logic [N-1:0] a, b;
        logic [1:0]   op;
        for (int i = 0; i < 30; i++) begin
            op = 2'($urandom_range(0, 3));
            a  = pick_value();
            b  = pick_value();
            run_checked($sformatf("rand%0d_op%0d", i, op), op, a, b);
        end
    endtask

    initial begin
        n_compared = 0;
        n_mismatched = 0;
        test_reset();
        test_directed();
        test_div_by_zero();
        test_flush();
        test_back_to_back();
        test_async_reset();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule
